// File: rtl/lcd_pkg.sv
// Shared command codes, FSM state type and frame constants for the LCD command host.
package lcd_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE      = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SHIFTUP    = 3'd1;
  localparam logic [CMD_W-1:0] CMD_SHIFTDOWN  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_SHIFTLEFT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_SHIFTRIGHT = 3'd4;
  localparam logic [CMD_W-1:0] CMD_AVERAGE    = 3'd5;
  localparam logic [CMD_W-1:0] CMD_MIRRORX    = 3'd6;
  localparam logic [CMD_W-1:0] CMD_MIRRORY    = 3'd7;

  localparam int unsigned IMG_WORDS = 64;
  localparam int unsigned CSUM_W    = 14;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_ISSUE,
    ST_GAP,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Circular command buffer; pushes are refused when full, pops when empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] wdata,
  input  logic             pop,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// LCD command host: queues upstream commands, issues them on the cmd/busy
// handshake, ends the frame after Write, and checks the write-back stream.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRB_RW,
  input  logic [5:0]        IRB_A,
  input  logic [7:0]        IRB_D,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CSUM_W-1:0] checksum,
  output logic [7:0]        xor_sig
);

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              wr_sent_q, wr_sent_d;
  logic              frame_err_q, frame_err_d;
  logic [CSUM_W-1:0] checksum_q, checksum_d;
  logic [7:0]        xor_q, xor_d;
  logic [5:0]        exp_a_q, exp_a_d;
  logic [6:0]        wcnt_q, wcnt_d;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CMD_W-1:0]  fifo_head;
  logic              enter_finish;

  assign in_ready   = !fifo_full && !wr_sent_q && (state_q != ST_FINISH);
  assign fifo_push  = in_valid && in_ready;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = (state_q == ST_FINISH);
  assign frame_err  = frame_err_q;
  assign checksum   = checksum_q;
  assign xor_sig    = xor_q;

  lcd_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: pop in WAIT, strobe in ISSUE, enforce a GAP, drain after Write.
  always_comb begin
    state_d      = state_q;
    cmd_d        = '0;
    cmd_valid_d  = 1'b0;
    wr_sent_d    = wr_sent_q;
    fifo_pop     = 1'b0;
    enter_finish = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!fifo_empty && !busy) begin
          fifo_pop    = 1'b1;
          cmd_d       = fifo_head;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
          if (fifo_head == CMD_WRITE) begin
            wr_sent_d = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = (cmd_q == CMD_WRITE) ? ST_DRAIN : ST_GAP;
      ST_GAP:   state_d = ST_WAIT;
      ST_DRAIN: begin
        if (done) begin
          state_d      = ST_FINISH;
          enter_finish = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_FINISH;
      default:   state_d = ST_WAIT;
    endcase
  end

  // Write monitor: address order, byte sum/XOR, write count; runs in every state.
  always_comb begin
    frame_err_d = frame_err_q;
    checksum_d  = checksum_q;
    xor_d       = xor_q;
    exp_a_d     = exp_a_q;
    wcnt_d      = wcnt_q;
    if (!IRB_RW) begin
      if (IRB_A != exp_a_q) begin
        frame_err_d = 1'b1;
      end
      checksum_d = checksum_q + CSUM_W'(IRB_D);
      xor_d      = xor_q ^ IRB_D;
      exp_a_d    = exp_a_q + 6'd1;
      if (wcnt_q != 7'd127) begin
        wcnt_d = wcnt_q + 7'd1;
      end
    end
    // The count check uses wcnt_d so a write coincident with done is included.
    if (enter_finish && (wcnt_d != 7'(IMG_WORDS))) begin
      frame_err_d = 1'b1;
    end
  end

  // State, output and monitor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      wr_sent_q   <= 1'b0;
      frame_err_q <= 1'b0;
      checksum_q  <= '0;
      xor_q       <= '0;
      exp_a_q     <= '0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      wr_sent_q   <= wr_sent_d;
      frame_err_q <= frame_err_d;
      checksum_q  <= checksum_d;
      xor_q       <= xor_d;
      exp_a_q     <= exp_a_d;
      wcnt_q      <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Randomized self-checking bench for lcd_cmd_host with a frame-level reference model.
module tb_lcd_cmd_host;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_cmd = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic        IRB_RW = 1'b1;
  logic [5:0]  IRB_A = '0;
  logic [7:0]  IRB_D = '0;
  logic        frame_done;
  logic        frame_err;
  logic [13:0] checksum;
  logic [7:0]  xor_sig;

  lcd_cmd_host #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid),
    .in_ready(in_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D),
    .frame_done(frame_done), .frame_err(frame_err), .checksum(checksum),
    .xor_sig(xor_sig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Strobe observer: records every issued command with its cycle.
  logic [2:0] iss_q[$];
  int         iss_cyc[$];
  int         bad_space = 0;
  int         bad_idle = 0;
  logic       prev_v = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      iss_q.delete();
      iss_cyc.delete();
      bad_space = 0;
      bad_idle  = 0;
      prev_v    = 1'b0;
    end else begin
      if (cmd_valid) begin
        iss_q.push_back(cmd);
        iss_cyc.push_back(cyc);
        if (prev_v) bad_space++;
      end else if (cmd != 3'd0) begin
        bad_idle++;
      end
      prev_v = cmd_valid;
    end
  end

  // Reference model: accepted commands in order, and the frame's write statistics.
  logic [2:0] exp_q[$];
  int         m_cnt;
  int         m_sum;
  int         m_xor;
  bit         m_aerr;
  int         last_acc;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt  = 0;
    m_sum  = 0;
    m_xor  = 0;
    m_aerr = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    IRB_RW   = 1'b1;
    IRB_A    = '0;
    IRB_D    = '0;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic push(input logic [2:0] c);
    int n = 0;
    in_cmd   = c;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    check_eq("push_accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      last_acc = cyc + 1;
      exp_q.push_back(c);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_issued(input int n);
    int k = 0;
    while (iss_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    check_eq("issue_count", 32'(iss_q.size()), 32'(n));
    for (int i = 0; i < n && i < iss_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("issue_order%0d", i), 32'(iss_q[i]), 32'(exp_q[i]));
  endtask

  // Writes indices first..first+n-1; address = index mod 64, bumped by one at bad_idx.
  task automatic write_range(input int first, input int n, input bit rnd, input int bad_idx);
    int a;
    int d;
    for (int i = first; i < first + n; i++) begin
      a = i % 64;
      if (i == bad_idx) a = (a + 1) % 64;
      d = rnd ? int'($urandom_range(0, 255)) : (i % 64);
      IRB_RW = 1'b0;
      IRB_A  = 6'(a);
      IRB_D  = 8'(d);
      if (a != (m_cnt % 64)) m_aerr = 1'b1;
      m_sum = (m_sum + d) % 16384;
      m_xor = m_xor ^ d;
      if (m_cnt < 127) m_cnt++;
      tick();
    end
    IRB_RW = 1'b1;
  endtask

  task automatic check_mon(input string tag);
    check_eq({tag, "_spacing"}, 32'(bad_space), 32'd0);
    check_eq({tag, "_idle_cmd"}, 32'(bad_idle), 32'd0);
  endtask

  task automatic finish_frame(input string tag);
    check_eq({tag, "_done_pre"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_csum_pre"}, 32'(checksum), 32'(m_sum));
    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    check_eq({tag, "_frame_err"}, 32'(frame_err), 32'((m_aerr || m_cnt != 64) ? 1 : 0));
    check_eq({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
    check_eq({tag, "_xor"}, 32'(xor_sig), 32'(m_xor));
    tick();
    check_eq({tag, "_ready_fin"}, 32'(in_ready), 32'd0);
    check_mon(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;

    // Reset state.
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_cmd", 32'(cmd), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    check_eq("rst_xor", 32'(xor_sig), 32'd0);
    do_reset();

    // Single command then Write; clean D=A frame.
    push(3'd3);
    c = 3'(last_acc);
    push(3'd0);
    wait_issued(2);
    check_eq("first_latency", 32'(iss_cyc.size() > 0 ? iss_cyc[0] : -1), 32'(int'(c) + 1));
    check_eq("gap_3_0", 32'((iss_cyc.size() > 1 && iss_cyc[1] - iss_cyc[0] >= 2) ? 1 : 0), 32'd1);
    check_eq("ready_after_write", 32'(in_ready), 32'd0);
    write_range(0, 64, 1'b0, -1);
    check_eq("csum_2016", 32'(checksum), 32'd2016);
    finish_frame("clean");

    // Busy stall with writes arriving before DRAIN.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(3'($urandom_range(1, 7)));
    write_range(0, 10, 1'b1, -1);
    repeat (10) tick();
    check_eq("stall_no_issue", 32'(iss_q.size()), 32'd0);
    busy = 1'b0;
    wait_issued(4);
    push(3'd0);
    wait_issued(5);
    write_range(10, 54, 1'b1, -1);
    finish_frame("stall");

    // FIFO full, held ninth push, address error at 5.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 8; i++) push(3'($urandom_range(1, 7)));
    check_eq("full_ready", 32'(in_ready), 32'd0);
    c = 3'($urandom_range(1, 7));
    in_cmd   = c;
    in_valid = 1'b1;
    repeat (5) tick();
    check_eq("full_hold_ready", 32'(in_ready), 32'd0);
    check_eq("full_no_issue", 32'(iss_q.size()), 32'd0);
    busy = 1'b0;
    push(c);
    wait_issued(9);
    push(3'd0);
    wait_issued(10);
    write_range(0, 64, 1'b1, 5);
    finish_frame("addr_err");

    // Short frame: 63 writes.
    do_reset();
    push(3'd0);
    wait_issued(1);
    write_range(0, 63, 1'b1, -1);
    finish_frame("short");

    // Reset mid-drain after 30 writes, then a clean frame.
    do_reset();
    push(3'd0);
    wait_issued(1);
    write_range(0, 30, 1'b1, -1);
    check_eq("mid_csum_pre", 32'(checksum), 32'(m_sum));
    #2 reset = 1'b1;
    #1;
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("mid_cmd", 32'(cmd), 32'd0);
    check_eq("mid_frame_done", 32'(frame_done), 32'd0);
    check_eq("mid_frame_err", 32'(frame_err), 32'd0);
    check_eq("mid_checksum", 32'(checksum), 32'd0);
    check_eq("mid_xor", 32'(xor_sig), 32'd0);
    do_reset();
    write_range(0, 16, 1'b1, -1);
    push(3'd0);
    wait_issued(1);
    write_range(16, 48, 1'b1, -1);
    finish_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
